// File: rtl/integer_alu.sv
// integer_alu: memory-mapped 16-bit integer arithmetic unit on the 256-bit
// system bus. The controller writes OPA, OPB and CMD, polls STATUS and then
// reads RESULT. ADD/SUB/MUL finish one clock after the CMD write. DIV runs a
// restoring divider that produces one quotient bit per clock.
//
// Register map (address[3:0]): 0 OPA (W), 1 OPB (W), 2 CMD (W),
// 3 RESULT (R), 4 STATUS (R: bit0 busy, bit1 error, bit2 done).
// Reads of any other offset return 0.
//
// Ports:
//   Clk      rising-edge clock
//   nReset   asynchronous active-low reset
//   DataBus  shared 256-bit bus; bits [15:0] carry data, upper bits read 0
//   address  [15:12] block select, [3:0] register select
//   nRead    active-low read strobe (combinational read)
//   nWrite   active-low write strobe (captured on posedge Clk)
//
// Optional feature: define INTEGER_ALU_MOD_EN to enable opcode 4 (MOD). MOD
// returns the remainder and uses the divider path. Without the macro,
// opcode 4 is illegal.
module integer_alu #(
    parameter logic [3:0]  BASE_NIBBLE = 4'h3,
    parameter int unsigned DIV_CYCLES  = 16
) (
    input  logic          Clk,
    input  logic          nReset,
    inout  wire  [255:0]  DataBus,
    input  logic [15:0]   address,
    input  logic          nRead,
    input  logic          nWrite
);

`ifdef INTEGER_ALU_MOD_EN
    localparam bit MOD_EN = 1'b1;
`else
    localparam bit MOD_EN = 1'b0;
`endif

    localparam int unsigned CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [15:0] OP_ADD = 16'd0;
    localparam logic [15:0] OP_SUB = 16'd1;
    localparam logic [15:0] OP_MUL = 16'd2;
    localparam logic [15:0] OP_DIV = 16'd3;
    localparam logic [15:0] OP_MOD = 16'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIVIDE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     opa, opb;
    logic [15:0]     op_q, a_q, b_q;
    logic [15:0]     result_q;
    logic            err_q, done_q;
    logic [15:0]     rem_q, quo_q;
    logic [CW-1:0]   cnt_q;

    logic            sel, wr_en, rd_en, idle, busy, cmd_wr, cmd_div, last_iter;
    logic [15:0]     wdata, rdata;
    logic [16:0]     rem_sh, diff;
    logic            take;
    logic [15:0]     rem_d, quo_d;
    logic [31:0]     prod;
    logic            unused_ok;

    assign wdata  = DataBus[15:0];
    assign sel    = (address[15:12] == BASE_NIBBLE);
    assign wr_en  = sel && !nWrite;
    // Reads are gated by reset so the bus is released for the whole reset.
    assign rd_en  = sel && !nRead && nWrite && nReset;
    assign idle   = (state_q == S_IDLE);
    assign busy   = !idle;
    assign cmd_wr = wr_en && idle && (address[3:0] == 4'd2);
    // A divide by zero skips the divider and reports the error from S_EXEC.
    assign cmd_div = ((wdata == OP_DIV) || (MOD_EN && (wdata == OP_MOD)))
                     && (opb != 16'd0);
    assign last_iter = (cnt_q == CW'(DIV_CYCLES - 1));
    assign prod   = {16'b0, a_q} * {16'b0, b_q};

    // Restoring divide step. The partial remainder is always below the
    // divisor, so the shifted value fits in 17 bits and diff[16] is the borrow.
    assign rem_sh = {rem_q, quo_q[15]};
    assign diff   = rem_sh - {1'b0, b_q};
    assign take   = !diff[16];
    assign rem_d  = take ? diff[15:0] : rem_sh[15:0];
    assign quo_d  = {quo_q[14:0], take};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_wr) state_d = cmd_div ? S_DIVIDE : S_EXEC;
            S_EXEC:   state_d = S_IDLE;
            S_DIVIDE: if (last_iter) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            opa      <= '0;
            opb      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en && idle) begin
                case (address[3:0])
                    4'd0:    opa <= wdata;
                    4'd1:    opb <= wdata;
                    default: ;
                endcase
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_wr) begin
                        op_q   <= wdata;
                        a_q    <= opa;
                        b_q    <= opb;
                        err_q  <= 1'b0;
                        done_q <= 1'b0;
                        rem_q  <= '0;
                        quo_q  <= opa;
                        cnt_q  <= '0;
                    end
                end
                S_EXEC: begin
                    done_q <= 1'b1;
                    case (op_q)
                        OP_ADD:  result_q <= a_q + b_q;
                        OP_SUB:  result_q <= a_q - b_q;
                        OP_MUL:  result_q <= prod[15:0];
                        default: begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                        end
                    endcase
                end
                S_DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        result_q <= (op_q == OP_MOD) ? rem_d : quo_d;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (address[3:0])
            4'd3:    rdata = result_q;
            4'd4:    rdata = {13'b0, done_q, err_q, busy};
            default: ;
        endcase
    end

    assign DataBus = rd_en ? {240'b0, rdata} : {256{1'bz}};

    assign unused_ok = ^{address[11:4], DataBus[255:16]};

endmodule

// File: tb/tb_integer_alu.sv
module tb_integer_alu;

    logic          Clk = 1'b0;
    logic          nReset = 1'b0;
    logic [15:0]   address = '0;
    logic          nRead = 1'b1;
    logic          nWrite = 1'b1;
    logic          tb_en = 1'b0;
    logic [255:0]  tb_dat = '0;
    logic          probe = 1'b0;
    wire  [255:0]  DataBus;

    assign DataBus = tb_en ? tb_dat : {256{1'bz}};

    integer_alu #(.BASE_NIBBLE(4'h3), .DIV_CYCLES(16)) dut (
        .Clk     (Clk),
        .nReset  (nReset),
        .DataBus (DataBus),
        .address (address),
        .nRead   (nRead),
        .nWrite  (nWrite)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] val;
        bit          undriven;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Monitor: any bus read (or explicit idle-bus probe) pops one expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (probe || (!nRead && nWrite)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read got=%h want=none", DataBus[15:0]);
            end else begin
                e = sb.pop_front();
                if (e.undriven) begin
                    if (!((DataBus === {256{1'bz}}) || (DataBus === '0))) begin
                        bad++;
                        $display("FAIL %s got=%h want=undriven", e.name, DataBus);
                    end
                end else if (DataBus !== {240'b0, e.val}) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", e.name, DataBus, {240'b0, e.val});
                end
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a;
        tb_dat  = {240'b0, d};
        tb_en   = 1'b1;
        nWrite  = 1'b0;
        @(posedge Clk); #1;
        nWrite  = 1'b1;
        tb_en   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] v, input string n);
        sb.push_back('{val: v, undriven: 1'b0, name: n});
        address = a;
        nRead   = 1'b0;
        @(posedge Clk); #1;
        nRead   = 1'b1;
    endtask

    task automatic rd_z(input logic [15:0] a, input string n);
        sb.push_back('{val: 16'h0, undriven: 1'b1, name: n});
        address = a;
        nRead   = 1'b0;
        @(posedge Clk); #1;
        nRead   = 1'b1;
    endtask

    task automatic probe_z(input string n);
        sb.push_back('{val: 16'h0, undriven: 1'b1, name: n});
        probe = 1'b1;
        @(posedge Clk); #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    // Load both operands, issue a command, wait the given clocks for completion.
    task automatic op(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input int wait_n);
        wr(16'h3000, a);
        wr(16'h3001, b);
        wr(16'h3002, c);
        idle(wait_n);
    endtask

    initial begin
        @(posedge Clk); #1;
        rd_z(16'h3004, "reset_read_released");
        probe_z("reset_bus_idle");
        nReset = 1'b1;
        rd(16'h3003, 16'h0000, "reset_result");
        rd(16'h3004, 16'h0000, "reset_status");

        op(16'h0012, 16'h000C, 16'd0, 1);
        rd(16'h3003, 16'h001E, "add_result");
        rd(16'h3004, 16'h0004, "add_status");

        op(16'h0003, 16'h000C, 16'd2, 1);
        rd(16'h3003, 16'h0024, "mul_result");

        op(16'h0024, 16'h0016, 16'd1, 1);
        rd(16'h3003, 16'h000E, "sub_result");

        op(16'h0000, 16'h0001, 16'd1, 1);
        rd(16'h3003, 16'hFFFF, "sub_wrap");

        // Divide: CMD captured at edge E0, quotient lands at E16.
        wr(16'h3000, 16'h0024);
        wr(16'h3001, 16'h0003);
        wr(16'h3002, 16'd3);
        rd(16'h3003, 16'hFFFF, "div_result_held");
        rd(16'h3004, 16'h0001, "div_busy_early");
        wr(16'h3002, 16'd0);
        wr(16'h3000, 16'hFFFF);
        idle(11);
        rd(16'h3004, 16'h0001, "div_busy_last");
        rd(16'h3003, 16'h000C, "div_result");
        rd(16'h3004, 16'h0004, "div_status");

        // OPA is still 0x0024 if the write during busy was dropped.
        wr(16'h3002, 16'd0);
        idle(1);
        rd(16'h3003, 16'h0027, "busy_write_ignored");

        wr(16'h3001, 16'h0000);
        wr(16'h3002, 16'd3);
        idle(1);
        rd(16'h3003, 16'h0000, "div0_result");
        rd(16'h3004, 16'h0006, "div0_status");

        wr(16'h3001, 16'h0005);
        wr(16'h3002, 16'd0);
        idle(1);
        rd(16'h3003, 16'h0029, "after_err_result");
        rd(16'h3004, 16'h0004, "cmd_clears_error");

        wr(16'h3002, 16'd7);
        idle(1);
        rd(16'h3004, 16'h0006, "illegal_status");
        rd(16'h3003, 16'h0000, "illegal_result");

`ifdef INTEGER_ALU_MOD_EN
        op(16'h0024, 16'h000E, 16'd4, 16);
        rd(16'h3003, 16'h0008, "mod_result");
        rd(16'h3004, 16'h0004, "mod_status");
`else
        op(16'h0024, 16'h000E, 16'd4, 1);
        rd(16'h3004, 16'h0006, "op4_illegal_status");
        rd(16'h3003, 16'h0000, "op4_illegal_result");
`endif

        op(16'h0024, 16'h000E, 16'd0, 1);
        rd(16'h3003, 16'h0032, "add2_result");
        rd_z(16'h4003, "other_block_undriven");
        rd(16'h3005, 16'h0000, "offset5_zero");

        // Reset in the middle of a divide.
        op(16'h0024, 16'h0003, 16'd3, 4);
        rd(16'h3004, 16'h0001, "mid_div_busy");
        nReset = 1'b0;
        probe_z("mid_reset_bus");
        nReset = 1'b1;
        rd(16'h3003, 16'h0000, "mid_reset_result");
        rd(16'h3004, 16'h0000, "mid_reset_status");
        wr(16'h3001, 16'h0007);
        wr(16'h3002, 16'd0);
        idle(1);
        rd(16'h3003, 16'h0007, "post_reset_opa_cleared");

        @(negedge Clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/integer_alu.md
Name: integer_alu

Overview:
- Memory-mapped 16-bit integer arithmetic unit on the shared 256-bit system bus, alongside main memory, instruction memory, the matrix ALU and the execution controller.
- The execution controller writes two operands and a command, polls status, then reads the result back.
- Performs add, subtract, multiply and divide on unsigned 16-bit values carried in DataBus[15:0].

Parameters:
- BASE_NIBBLE, 4'h3, value of address[15:12] that selects this block.
- DIV_CYCLES, 16, number of iterations of the restoring divider (one quotient bit per clock).

Ports:
- Clk  input  1  system clock, rising-edge active.
- nReset  input  1  asynchronous active-low reset.
- DataBus  inout  256  shared data bus; only bits [15:0] are significant, upper bits are driven 0 when this block drives.
- address  input  16  bus address; [15:12] selects the block, [3:0] selects the register.
- nRead  input  1  active-low read strobe.
- nWrite  input  1  active-low write strobe.

Behaviour:
- Select = (address[15:12] == BASE_NIBBLE).
- Register map, by address[3:0]:
  - 0: OPA, write.
  - 1: OPB, write.
  - 2: CMD, write; the value written is the opcode.
  - 3: RESULT, read.
  - 4: STATUS, read. bit0 busy, bit1 error, bit2 done.
  - Any other offset: reads return 0, writes are ignored.
- Writes: captured at posedge Clk when select and nWrite=0; data is DataBus[15:0].
- Reads: combinational. When select, nRead=0 and nWrite=1, drive {240'b0, reg}; otherwise drive 256'bz. Never drive while nWrite=0.
- Opcodes:
  - 0 ADD: (OPA+OPB) mod 2^16.
  - 1 SUB: (OPA-OPB) mod 2^16, wrap-around allowed.
  - 2 MUL: lower 16 bits of the 32-bit product.
  - 3 DIV: floor(OPA/OPB).
  - Any other opcode: illegal.
- Writing CMD starts the operation. ADD, SUB and MUL complete on the next posedge: RESULT updated, done=1, busy=0.
- DIV FSM: IDLE -> DIVIDE (DIV_CYCLES clocks, busy=1) -> IDLE.
  - On exit, RESULT = quotient and done=1.
  - RESULT keeps its previous value until completion.
- Divide by zero: no iteration; next clock sets RESULT=0, error=1, done=1.
- Illegal opcode: next clock sets RESULT=0, error=1, done=1.
- Writing CMD clears done and error for the new operation.
- While busy=1, writes to OPA, OPB and CMD are ignored. Reads are allowed; STATUS shows busy.
- Operands are sampled when CMD is written; later OPA/OPB writes do not affect an operation in flight.
- Reset, including mid-divide: OPA, OPB, RESULT, STATUS all 0, FSM returns to IDLE, DataBus released to z.
- A simultaneous nRead and nWrite with select: the write takes effect and the bus is not driven.

Optional Feature:
- Macro INTEGER_ALU_MOD_EN.
- Defined: opcode 4 = MOD, giving OPA mod OPB through the same divider path and latency (remainder). MOD with OPB=0 gives RESULT=0, error=1.
- Undefined: opcode 4 is illegal (RESULT=0, error=1).

Test Plan:
- Reset: assert nReset=0 mid-operation -> RESULT=0, STATUS=0, DataBus=z while not read.
- ADD: OPA=0x0012, OPB=0x000C, CMD=0 -> after 1 clock RESULT=0x001E, STATUS=0x4.
- MUL and SUB:
  - OPA=0x0003, OPB=0x000C, CMD=2 -> RESULT=0x0024.
  - OPA=0x0024, OPB=0x0016, CMD=1 -> RESULT=0x000E.
  - OPA=0x0000, OPB=0x0001, CMD=1 -> RESULT=0xFFFF.
- DIV:
  - OPA=0x0024, OPB=0x0003, CMD=3 -> busy=1 for 16 clocks, then RESULT=0x000C.
  - A CMD or OPA write during busy is ignored.
- Errors:
  - DIV with OPB=0 -> RESULT=0, STATUS=0x6.
  - CMD=7 -> STATUS=0x6.
  - With INTEGER_ALU_MOD_EN: OPA=0x0024, OPB=0x000E, CMD=4 -> RESULT=0x0008. Without it, CMD=4 -> STATUS=0x6.
- Bus isolation: a read with address[15:12] != 3, or a read at offset 5 -> DataBus is not driven / returns 0 respectively.
